lives_hud_renderer: RTL
=======================

Name: lives_hud_renderer

Overview:
Parametrised heart-row HUD renderer and the next generation of the fixed 3-heart lives display. It draws up to MAX_LIVES hearts from an external sprite ROM and pipelines pixel generation to match ROM latency. Lives updates are latched only at frame boundaries, so a frame is never torn. A lost heart blinks before it disappears. Output feeds the VGA pixel mixer as an overlay with its own active flag.

Parameters:
MAX_LIVES, 5, number of heart slots (1..8)
LIVES_W, 3, width of lives input
H_W, 10, width of h_count
V_W, 10, width of v_count (fixes 9-bit overflow at Y>=512)
HEART_W, 16, sprite width in pixels (power of 2)
HEART_H, 16, sprite height in pixels (power of 2)
SPACING, 8, gap between hearts in pixels
X_START, 160, left edge of slot 0
Y_POS, 440, top edge of heart row
BLINK_HALF, 8, frames per blink half-period
BLINK_NUM, 3, number of off/on blinks before removal

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse at start of vertical blank
lives  in  LIVES_W  requested lives count
h_count  in  H_W  current column
v_count  in  V_W  current row
sprite_addr  out  log2(HEART_W*HEART_H)  ROM address {y,x}
sprite_data  in  6  ROM data RRGGBB, valid 1 cycle after sprite_addr
vga_r  out  3  red
vga_g  out  3  green
vga_b  out  3  blue
hud_active  out  1  pixel is an opaque HUD pixel
blinking  out  1  loss animation in progress

Behaviour:
- Reset: all outputs 0. disp_lives=0, prev_lives=0, FSM=IDLE, counters 0.
- Slot k left edge = X_START + k*(HEART_W+SPACING). Compute at elaboration in H_W+4 bits. Any slot with edge+HEART_W > 2^H_W is never drawn; no wrap.
- Lives clamp: eff = min(lives, MAX_LIVES).
- Frame latch: on frame_start, disp_lives <= eff. Mid-frame changes of lives have no effect until the next frame_start.
- Pipeline stage 1 (registered): in_row = v_count in [Y_POS, Y_POS+HEART_H). Find the slot index k containing h_count and register it. Set sprite_addr = {v_count-Y_POS, h_count-slot_edge}; 0 when not in a slot. Register the valid flag.
- Stage 2 (registered): the slot is visible if k < disp_lives, or k == blink_slot while the FSM is in BLINK_ON.
- Transparency: sprite_data==6'b0 is transparent.
- Visible and opaque: vga_x = {data pair, 1'b0}, hud_active=1. Otherwise vga=0, hud_active=0.
- Total latency h/v_count -> vga/hud_active is 2 cycles.
- FSM (advances only on frame_start):
  - IDLE: if eff < disp_lives, then blink_slot = disp_lives-1, go to BLINK_OFF, frame_cnt=0, blink_cnt=0. disp_lives still latches eff.
  - BLINK_OFF -> BLINK_ON after BLINK_HALF frames. BLINK_ON -> BLINK_OFF after BLINK_HALF frames, with blink_cnt++.
  - After BLINK_NUM full off/on pairs, return to IDLE.
  - Multi-life loss in one frame: only the highest lost slot blinks; the others vanish immediately.
- Loss during blink: restart with the new highest lost slot; counters cleared.
- Gain during blink: if eff > blink_slot, abort to IDLE; the heart shows solid. A gain otherwise appears at the next frame_start.
- blinking = (FSM != IDLE).
- lives=0: nothing drawn except an active blink of slot 0.
- frame_start and in-row pixel in the same cycle: the pixel uses the new disp_lives.
- Reset mid-animation: immediate return to reset state; no hearts drawn until the first frame_start.

Optional Feature:
LIVES_HUD_EMPTY_SLOT_EN:
- Defined: slots k >= disp_lives (and not blinking ON) draw the sprite dimmed. Each channel = {1'b0, data pair MSB, 1'b0}, with hud_active=1 for opaque pixels.
- Undefined: such slots are transparent (black, hud_active=0).

Test Plan:
- Reset, then lives=3 and frame_start. Pixel (h=160, v=440) with opaque ROM data 6'b110000 gives vga_r=3'b110 2 cycles later. h=232 (slot 3) gives hud_active=0.
- lives=7 with MAX_LIVES=5 and frame_start: slots 0..4 drawn; pixel at slot 4 edge (h=256) is active.
- lives changed 3->2 mid-frame: current frame still shows 3 hearts. At the next frame_start, blinking=1 and slot 2 is off for 8 frames, then on for 8. After 3 pairs (48 frames), blinking=0 and slot 2 is gone.
- Blinking on slot 2, lives 2->3: at frame_start the FSM returns to IDLE, slot 2 is solid, blinking=0.
- lives 5->1 in one frame: slot 4 blinks, slots 1..3 are off immediately. rst_n asserted at frame 10 of the blink: all outputs 0 asynchronously, FSM=IDLE.
- Transparent ROM data 6'b000000 inside a visible slot gives hud_active=0 and vga=0. With LIVES_HUD_EMPTY_SLOT_EN, lives=1 and data 6'b111111 at slot 2 give vga_r=3'b010 and hud_active=1.

Source files
------------

// File: rtl/lives_hud_renderer.sv
// rtl/lives_hud_renderer.sv - heart-row lives HUD overlay with frame-latched count and loss blink.
// Optional build macro LIVES_HUD_EMPTY_SLOT_EN draws empty slots as dimmed hearts.
module lives_hud_renderer #(
  parameter int MAX_LIVES  = 5,
  parameter int LIVES_W    = 3,
  parameter int H_W        = 10,
  parameter int V_W        = 10,
  parameter int HEART_W    = 16,
  parameter int HEART_H    = 16,
  parameter int SPACING    = 8,
  parameter int X_START    = 160,
  parameter int Y_POS      = 440,
  parameter int BLINK_HALF = 8,
  parameter int BLINK_NUM  = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  frame_start,
  input  logic [LIVES_W-1:0]                    lives,
  input  logic [H_W-1:0]                        h_count,
  input  logic [V_W-1:0]                        v_count,
  output logic [$clog2(HEART_W*HEART_H)-1:0]    sprite_addr,
  input  logic [5:0]                            sprite_data,
  output logic [2:0]                            vga_r,
  output logic [2:0]                            vga_g,
  output logic [2:0]                            vga_b,
  output logic                                  hud_active,
  output logic                                  blinking
);

  localparam int HX_W = $clog2(HEART_W);
  localparam int HY_W = $clog2(HEART_H);
  localparam int FC_W = $clog2(BLINK_HALF + 1);
  localparam int BC_W = $clog2(BLINK_NUM + 1);

  typedef enum logic [1:0] {IDLE, BLINK_OFF, BLINK_ON} state_t;

  function automatic logic [H_W+3:0] slot_edge(input int k);
    return (H_W+4)'(X_START + k * (HEART_W + SPACING));
  endfunction

  // Slots running past the right edge of the counter range are dropped, never wrapped.
  function automatic bit slot_fits(input int k);
    return (X_START + k * (HEART_W + SPACING) + HEART_W) <= (1 << H_W);
  endfunction

  logic [H_W+3:0]  hx;
  logic [V_W+3:0]  vy, yoff;
  logic            in_row, hit;
  logic [3:0]      slot_c;
  logic [HX_W-1:0] xoff;

  logic            s1_valid;
  logic [3:0]      s1_slot;

  state_t          state, state_n;
  logic [3:0]      disp_lives, disp_n, blink_slot, slot_n, eff;
  logic [FC_W-1:0] frame_cnt, fc_n;
  logic [BC_W-1:0] blink_cnt, bc_n;

  logic            vis, opaque;
  logic [2:0]      r_n, g_n, b_n;
  logic            act_n;

  always_comb begin
    hx     = (H_W+4)'(h_count);
    vy     = (V_W+4)'(v_count);
    yoff   = vy - (V_W+4)'(Y_POS);
    in_row = (vy >= (V_W+4)'(Y_POS)) && (vy < (V_W+4)'(Y_POS + HEART_H));
    hit    = 1'b0;
    slot_c = '0;
    xoff   = '0;
    for (int k = 0; k < MAX_LIVES; k++) begin
      if (slot_fits(k) && (hx >= slot_edge(k)) &&
          (hx < slot_edge(k) + (H_W+4)'(HEART_W))) begin
        hit    = 1'b1;
        slot_c = 4'(k);
        xoff   = HX_W'(hx - slot_edge(k));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_slot     <= '0;
      sprite_addr <= '0;
    end else begin
      s1_valid    <= in_row && hit;
      s1_slot     <= slot_c;
      sprite_addr <= (in_row && hit) ? {HY_W'(yoff), xoff} : '0;
    end
  end

  assign eff = (int'(lives) > MAX_LIVES) ? 4'(MAX_LIVES) : 4'(lives);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      disp_lives <= '0;
      blink_slot <= '0;
      frame_cnt  <= '0;
      blink_cnt  <= '0;
    end else begin
      state      <= state_n;
      disp_lives <= disp_n;
      blink_slot <= slot_n;
      frame_cnt  <= fc_n;
      blink_cnt  <= bc_n;
    end
  end

  always_comb begin
    state_n = state;
    disp_n  = disp_lives;
    slot_n  = blink_slot;
    fc_n    = frame_cnt;
    bc_n    = blink_cnt;
    if (frame_start) begin
      disp_n = eff;
      // Any loss (also mid-animation) restarts the blink on the highest heart being removed.
      if (eff < disp_lives) begin
        state_n = BLINK_OFF;
        slot_n  = disp_lives - 4'd1;
        fc_n    = '0;
        bc_n    = '0;
      end else if (state != IDLE) begin
        if (eff > blink_slot) begin
          state_n = IDLE;
          fc_n    = '0;
          bc_n    = '0;
        end else if (frame_cnt == FC_W'(BLINK_HALF - 1)) begin
          fc_n = '0;
          if (state == BLINK_OFF) begin
            state_n = BLINK_ON;
          end else if (blink_cnt == BC_W'(BLINK_NUM - 1)) begin
            state_n = IDLE;
            bc_n    = '0;
          end else begin
            state_n = BLINK_OFF;
            bc_n    = blink_cnt + 1'b1;
          end
        end else begin
          fc_n = frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blinking = (state != IDLE);

  always_comb begin
    vis    = (s1_slot < disp_lives) || ((state == BLINK_ON) && (s1_slot == blink_slot));
    opaque = |sprite_data;
    r_n    = '0;
    g_n    = '0;
    b_n    = '0;
    act_n  = 1'b0;
    if (s1_valid && opaque) begin
      if (vis) begin
        r_n   = {sprite_data[5:4], 1'b0};
        g_n   = {sprite_data[3:2], 1'b0};
        b_n   = {sprite_data[1:0], 1'b0};
        act_n = 1'b1;
      end
`ifdef LIVES_HUD_EMPTY_SLOT_EN
      else begin
        r_n   = {1'b0, sprite_data[5], 1'b0};
        g_n   = {1'b0, sprite_data[3], 1'b0};
        b_n   = {1'b0, sprite_data[1], 1'b0};
        act_n = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      hud_active <= 1'b0;
    end else begin
      vga_r      <= r_n;
      vga_g      <= g_n;
      vga_b      <= b_n;
      hud_active <= act_n;
    end
  end

endmodule
